// File: rtl/msg_request_queue_if.sv
// ============================================================================
// Module   : msg_request_queue_if
// Brief    : Request-side and create-message-engine signals of msg_request_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 6
`endif
`ifndef LOGON
`define LOGON 4'h1
`endif
`ifndef LOGOUT
`define LOGOUT 4'h2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'h3
`endif
`ifndef resendReq
`define resendReq 4'h4
`endif

interface msg_request_queue_if #(
    parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
    parameter int SIZE        = `VALUE_SIZE,
    parameter int DEPTH       = 4
);
    logic                     initiate_msg_i;
    logic [3:0]               create_message_i;
    logic [3:0]               error_type_i;
    logic [VALUE_WIDTH-1:0]   targetCompId_i;
    logic [SIZE-1:0]          s_v_targetCompId_i;
    logic                     cm_busy_i;
    logic                     cm_done_i;

    logic                     start_o;
    logic [3:0]               msg_type_o;
    logic [3:0]               error_type_o;
    logic [VALUE_WIDTH-1:0]   targetCompId_o;
    logic [SIZE-1:0]          s_v_targetCompId_o;
    logic [$clog2(DEPTH):0]   count_o;
    logic                     full_o;
    logic                     overflow_o;
    logic                     timeout_err_o;

    // Queue side
    modport slave (
        input  initiate_msg_i, create_message_i, error_type_i,
               targetCompId_i, s_v_targetCompId_i, cm_busy_i, cm_done_i,
        output start_o, msg_type_o, error_type_o, targetCompId_o,
               s_v_targetCompId_o, count_o, full_o, overflow_o, timeout_err_o
    );

    // Session manager / create-message engine side
    modport master (
        output initiate_msg_i, create_message_i, error_type_i,
               targetCompId_i, s_v_targetCompId_i, cm_busy_i, cm_done_i,
        input  start_o, msg_type_o, error_type_o, targetCompId_o,
               s_v_targetCompId_o, count_o, full_o, overflow_o, timeout_err_o
    );
endinterface

`default_nettype wire

// File: rtl/msg_request_queue.sv
// ============================================================================
// Module   : msg_request_queue
// Brief    : FIFO of message requests feeding a create-message engine, one
//            outstanding request at a time, with a completion watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef VALUE_DATA_WIDTH
`define VALUE_DATA_WIDTH 32
`endif
`ifndef VALUE_SIZE
`define VALUE_SIZE 6
`endif

module msg_request_queue #(
    parameter int VALUE_WIDTH  = `VALUE_DATA_WIDTH,
    parameter int SIZE         = `VALUE_SIZE,
    parameter int DEPTH        = 4,
    parameter int DONE_TIMEOUT = 1024
) (
    input  wire logic           clk,
    input  wire logic           rst,
    msg_request_queue_if.slave  bus
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_ENTRY_W = 8 + VALUE_WIDTH + SIZE;
    localparam int c_WDOG_W  = $clog2(DONE_TIMEOUT + 1);
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'(DONE_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0]  c_FULL_CNT  = c_CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_ENTRY_W-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_CNT_W-1:0]     r_count;
    logic                   r_overflow;
    logic [c_WDOG_W-1:0]    r_wdog;

    logic                   r_start;
    logic                   r_timeout;
    logic [3:0]             r_msg_type;
    logic [3:0]             r_error_type;
    logic [VALUE_WIDTH-1:0] r_comp_id;
    logic [SIZE-1:0]        r_comp_size;

    logic                   w_full;
    logic                   w_push_req;
    logic                   w_push;
    logic                   w_drop;
    logic                   w_pop;
    logic                   w_wdog_inc;
    logic                   w_timeout;
    logic [c_ENTRY_W-1:0]   w_head_entry;

    // Full is the registered occupancy, so a pop on the same edge never frees a slot for a push.
    assign w_full       = (r_count == c_FULL_CNT);
    assign w_push_req   = bus.initiate_msg_i && (bus.create_message_i != 4'd0);
    assign w_push       = w_push_req && !w_full;
    assign w_drop       = w_push_req && w_full;
    assign w_head_entry = r_mem[r_head];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_tail] <= {bus.create_message_i, bus.error_type_i,
                              bus.targetCompId_i, bus.s_v_targetCompId_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_wdog_inc   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && !bus.cm_busy_i) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_pop        = 1'b1;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                // Completion on the terminal watchdog cycle takes priority over the timeout.
                if (bus.cm_done_i) begin
                    w_state_next = S_IDLE;
                end else if (r_wdog == c_WDOG_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_wdog_inc = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (w_wdog_inc) begin
            r_wdog <= r_wdog + 1'b1;
        end else begin
            r_wdog <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_start      <= 1'b0;
            r_timeout    <= 1'b0;
            r_msg_type   <= '0;
            r_error_type <= '0;
            r_comp_id    <= '0;
            r_comp_size  <= '0;
        end else begin
            r_start   <= w_pop;
            r_timeout <= w_timeout;
            if (w_pop) begin
                {r_msg_type, r_error_type, r_comp_id, r_comp_size} <= w_head_entry;
            end
        end
    end

    assign bus.start_o            = r_start;
    assign bus.timeout_err_o      = r_timeout;
    assign bus.msg_type_o         = r_msg_type;
    assign bus.error_type_o       = r_error_type;
    assign bus.targetCompId_o     = r_comp_id;
    assign bus.s_v_targetCompId_o = r_comp_size;
    assign bus.count_o            = r_count;
    assign bus.full_o             = w_full;
    assign bus.overflow_o         = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_msg_request_queue.sv
// ============================================================================
// Module   : tb_msg_request_queue
// Brief    : Directed scoreboard bench for msg_request_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef LOGON
`define LOGON 4'h1
`endif
`ifndef LOGOUT
`define LOGOUT 4'h2
`endif
`ifndef HEARTBEAT
`define HEARTBEAT 4'h3
`endif
`ifndef resendReq
`define resendReq 4'h4
`endif

module tb_msg_request_queue;

    localparam int VW = 12;
    localparam int SZ = 4;
    localparam int DP = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic [3:0]    t;
        logic [3:0]    e;
        logic [VW-1:0] id;
        logic [SZ-1:0] sz;
    } req_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    req_t sb[$];

    msg_request_queue_if #(.VALUE_WIDTH(VW), .SIZE(SZ), .DEPTH(DP)) bus ();

    msg_request_queue #(
        .VALUE_WIDTH(VW), .SIZE(SZ), .DEPTH(DP), .DONE_TIMEOUT(TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] t, input logic [3:0] e,
                             input logic [VW-1:0] id, input logic [SZ-1:0] sz,
                             input bit accept);
        req_t r;
        r = '{t: t, e: e, id: id, sz: sz};
        bus.initiate_msg_i     = 1'b1;
        bus.create_message_i   = t;
        bus.error_type_i       = e;
        bus.targetCompId_i     = id;
        bus.s_v_targetCompId_i = sz;
        if (accept) sb.push_back(r);
        @(negedge clk);
        bus.initiate_msg_i   = 1'b0;
        bus.create_message_i = 4'd0;
    endtask

    task automatic check_payload(input string tag);
        req_t exp;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, "_type"}, bus.msg_type_o, exp.t);
        chk({tag, "_err"},  bus.error_type_o, exp.e);
        chk({tag, "_id"},   bus.targetCompId_o, exp.id);
        chk({tag, "_size"}, bus.s_v_targetCompId_o, exp.sz);
    endtask

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (bus.start_o !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_start"}, bus.start_o, 1'b1);
        check_payload(tag);
    endtask

    task automatic done_pulse();
        bus.cm_done_i = 1'b1;
        @(negedge clk);
        bus.cm_done_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"}, bus.start_o, 1'b0);
        chk({tag, "_count"}, bus.count_o, 0);
        chk({tag, "_full"},  bus.full_o, 1'b0);
        chk({tag, "_ovf"},   bus.overflow_o, 1'b0);
        chk({tag, "_tmo"},   bus.timeout_err_o, 1'b0);
        chk({tag, "_type"},  bus.msg_type_o, 4'd0);
        chk({tag, "_id"},    bus.targetCompId_o, 0);
    endtask

    initial begin
        int k;
        int starts;
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.initiate_msg_i     = 1'b0;
        bus.create_message_i   = 4'd0;
        bus.error_type_i       = 4'd0;
        bus.targetCompId_i     = '0;
        bus.s_v_targetCompId_i = '0;
        bus.cm_busy_i          = 1'b0;
        bus.cm_done_i          = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        // Single request latency: start two edges after the push edge
        drive_req(`LOGON, 4'h5, 12'hABC, 4'h3, 1'b1);
        chk("lat_count1", bus.count_o, 1);
        chk("lat_start_e1", bus.start_o, 1'b0);
        @(negedge clk);
        chk("lat_start_e2", bus.start_o, 1'b0);
        @(negedge clk);
        chk("lat_start_e3", bus.start_o, 1'b1);
        check_payload("lat");
        chk("lat_count0", bus.count_o, 0);
        @(negedge clk);
        chk("lat_no_consec", bus.start_o, 1'b0);
        chk("lat_hold_id", bus.targetCompId_o, 12'hABC);
        done_pulse();

        // Done while idle and zero-type request are both ignored
        done_pulse();
        repeat (3) @(negedge clk);
        chk("idle_done_start", bus.start_o, 1'b0);
        chk("idle_done_tmo", bus.timeout_err_o, 1'b0);
        drive_req(4'd0, 4'h1, 12'h111, 4'h1, 1'b0);
        chk("zero_type_count", bus.count_o, 0);
        chk("zero_type_ovf", bus.overflow_o, 1'b0);
        repeat (3) @(negedge clk);
        chk("zero_type_start", bus.start_o, 1'b0);

        // Fill past capacity while engine busy
        bus.cm_busy_i = 1'b1;
        drive_req(`LOGON,     4'h1, 12'h101, 4'h1, 1'b1);
        drive_req(`LOGOUT,    4'h2, 12'h202, 4'h2, 1'b1);
        drive_req(`HEARTBEAT, 4'h3, 12'h303, 4'h3, 1'b1);
        drive_req(`resendReq, 4'h4, 12'h404, 4'h4, 1'b1);
        drive_req(`LOGON,     4'h9, 12'h999, 4'h9, 1'b0);
        chk("full_count", bus.count_o, DP);
        chk("full_flag", bus.full_o, 1'b1);
        chk("full_ovf", bus.overflow_o, 1'b1);
        chk("full_busy_start", bus.start_o, 1'b0);
        bus.cm_busy_i = 1'b0;
        for (int i = 0; i < DP; i++) begin
            wait_start("drain");
            done_pulse();
        end
        repeat (3) @(negedge clk);
        chk("drain_count", bus.count_o, 0);
        chk("drain_full", bus.full_o, 1'b0);
        chk("drain_ovf_sticky", bus.overflow_o, 1'b1);
        chk("drain_no_5th", bus.start_o, 1'b0);

        // Watchdog timeout, then next entry still issued
        bus.cm_busy_i = 1'b1;
        drive_req(`HEARTBEAT, 4'h6, 12'h5A5, 4'h6, 1'b1);
        drive_req(`LOGOUT,    4'h7, 12'h6B6, 4'h7, 1'b1);
        bus.cm_busy_i = 1'b0;
        wait_start("tmo_a");
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (bus.timeout_err_o !== 1'b1 && k < 4 * TO);
        chk("tmo_latency", k, TO);
        chk("tmo_pulse", bus.timeout_err_o, 1'b1);
        @(negedge clk);
        chk("tmo_single", bus.timeout_err_o, 1'b0);
        wait_start("tmo_b");
        done_pulse();

        // Completion on the terminal watchdog cycle wins
        drive_req(`resendReq, 4'h8, 12'h7C7, 4'h8, 1'b1);
        wait_start("term");
        repeat (TO - 1) @(negedge clk);
        done_pulse();
        chk("term_no_tmo", bus.timeout_err_o, 1'b0);
        starts = 0;
        for (int i = 0; i < TO + 4; i++) begin
            @(negedge clk);
            if (bus.timeout_err_o === 1'b1 || bus.start_o === 1'b1) starts++;
        end
        chk("term_quiet", starts, 0);

        // Push and pop on the same edge at count 2
        bus.cm_busy_i = 1'b1;
        drive_req(`LOGON,  4'h1, 12'h0A1, 4'h1, 1'b1);
        drive_req(`LOGOUT, 4'h2, 12'h0B2, 4'h2, 1'b1);
        chk("pp_count_pre", bus.count_o, 2);
        bus.cm_busy_i = 1'b0;
        @(negedge clk);
        chk("pp_count_issue", bus.count_o, 2);
        drive_req(`HEARTBEAT, 4'h3, 12'h0C3, 4'h3, 1'b1);
        chk("pp_start", bus.start_o, 1'b1);
        check_payload("pp_x");
        chk("pp_count_same", bus.count_o, 2);
        done_pulse();
        wait_start("pp_y");
        done_pulse();
        wait_start("pp_z");
        done_pulse();
        repeat (3) @(negedge clk);
        chk("pp_count_end", bus.count_o, 0);

        // Asynchronous reset while waiting for completion with three queued
        bus.cm_busy_i = 1'b1;
        drive_req(`LOGON,     4'h1, 12'hD01, 4'h1, 1'b1);
        drive_req(`LOGOUT,    4'h2, 12'hD02, 4'h2, 1'b1);
        drive_req(`HEARTBEAT, 4'h3, 12'hD03, 4'h3, 1'b1);
        drive_req(`resendReq, 4'h4, 12'hD04, 4'h4, 1'b1);
        bus.cm_busy_i = 1'b0;
        wait_start("rst_a");
        chk("rst_pre_count", bus.count_o, 3);
        #2 rst = 1'b0;
        #1 check_all_zero("rst_async");
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.start_o === 1'b1 || bus.timeout_err_o === 1'b1) starts++;
        end
        chk("rst_quiet", starts, 0);
        chk("rst_count_after", bus.count_o, 0);
        drive_req(`LOGOUT, 4'hE, 12'hFED, 4'hC, 1'b1);
        wait_start("rst_new");
        done_pulse();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/msg_request_queue.md
MSG_REQUEST_QUEUE -- requirements
Module: msg_request_queue

Interface
REQ-001 Parameter VALUE_WIDTH, default `VALUE_DATA_WIDTH; width of targetCompId value.
REQ-002 Parameter SIZE, default `VALUE_SIZE; width of targetCompId size field.
REQ-003 Parameter DEPTH, default 4; queue entries, power of two, >=2.
REQ-004 Parameter DONE_TIMEOUT, default 1024; max cycles waiting for cm_done_i.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 initiate_msg_i  input  1  request strobe from session_manager.
REQ-008 create_message_i  input  4  message type code (`logon/`logout/`heartbeat/`resendReq); 0 = none.
REQ-009 error_type_i  input  4  error code accompanying the request.
REQ-010 targetCompId_i  input  VALUE_WIDTH  destination CompID value.
REQ-011 s_v_targetCompId_i  input  SIZE  destination CompID size.
REQ-012 cm_busy_i  input  1  create-message engine busy.
REQ-013 cm_done_i  input  1  create-message engine finished current message (1-cycle pulse).
REQ-014 start_o  output  1  1-cycle start pulse to create-message engine.
REQ-015 msg_type_o / error_type_o  output  4 / 4  issued request fields.
REQ-016 targetCompId_o / s_v_targetCompId_o  output  VALUE_WIDTH / SIZE  issued CompID.
REQ-017 count_o  output  $clog2(DEPTH)+1  entries held; full_o  output  1  count_o==DEPTH.
REQ-018 overflow_o  output  1  sticky: request dropped while full.
REQ-019 timeout_err_o  output  1  1-cycle pulse: engine failed to complete within DONE_TIMEOUT.

Function
REQ-020 Push: initiate_msg_i==1, create_message_i!=0 and full_o==0 at the edge -> write entry {type, error, CompID, size} at tail; tail wraps modulo DEPTH.
REQ-021 initiate_msg_i with create_message_i==0 SHALL be ignored (no push, no flag).
REQ-022 Push while full_o==1 (registered value, even if a pop occurs the same edge) -> entry dropped, overflow_o set and held until reset.
REQ-023 Simultaneous push and pop -> count_o unchanged; entries leave in strict FIFO order.
REQ-024 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-025 IDLE -> ISSUE when count_o>0 and cm_busy_i==0; otherwise remain.
REQ-026 ISSUE: start_o=1 for exactly one cycle; head fields loaded into payload outputs; head popped; next state WAIT_DONE.
REQ-027 WAIT_DONE: payload outputs held stable; cm_done_i==1 -> IDLE; watchdog counts cycles from entry.
REQ-028 Watchdog reaching DONE_TIMEOUT with cm_done_i==0 -> timeout_err_o pulse one cycle, -> IDLE; cm_done_i on the terminal cycle wins (no error).
REQ-029 cm_done_i outside WAIT_DONE SHALL be ignored.
REQ-030 Latency: push into empty queue, FSM IDLE, cm_busy_i==0 -> start_o high in the cycle following the second rising edge after push is sampled.
REQ-031 start_o SHALL never be high in two consecutive cycles; at most one request outstanding.
REQ-032 Payload outputs hold last issued values until next ISSUE; no bypass from inputs to outputs.

Reset
REQ-033 rst low, asynchronously: queue emptied, pointers 0, FSM IDLE, watchdog 0, all outputs 0 including overflow_o; an in-flight request is abandoned without timeout_err_o.

Verification
REQ-034 Push `logon, CompID 0xABC, busy=0 -> start_o pulse 2 edges later, msg_type_o=`logon, targetCompId_o=0xABC, count_o back to 0.
REQ-035 cm_busy_i=1, push 5 requests (DEPTH=4) -> count_o=4, full_o=1, overflow_o=1, 5th lost; release busy, issue in push order.
REQ-036 Issue, withhold cm_done_i for DONE_TIMEOUT cycles -> timeout_err_o single pulse, FSM IDLE, next entry issued.
REQ-037 Push and pop same edge at count 2 -> count_o stays 2; cm_done_i with FSM IDLE -> no effect.
REQ-038 Drop rst in WAIT_DONE with 3 queued -> all outputs 0 immediately, count_o=0, no start_o after release until new push.
